servo_slew_pwm: RTL and testbench

//  Per-joint servo driver downstream of the arm sequencer: takes a target pulse offset (DESIRED),

---
 rtl/servo_slew_pwm.sv | 123 ++++++++++++
 tb/tb_servo_slew_pwm.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/servo_slew_pwm.sv
// Per-joint servo driver: slews the commanded position toward a clamped target once per PWM frame,
// generates the registered servo pulse, and raises FLAG after the position has held on target.
module servo_slew_pwm #(
    parameter int unsigned PERIOD        = 2000000,
    parameter int unsigned BASE_WIDTH    = 50000,
    parameter int unsigned MAX_POS       = 200000,
    parameter int unsigned STEP          = 2000,
    parameter int unsigned INIT_POS      = 191394,
    parameter int unsigned SETTLE_FRAMES = 5
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [19:0] DESIRED,
    output logic        PWM,
    output logic        FLAG,
    output logic [19:0] POS
);

    localparam int unsigned CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int unsigned PW = ((CW > 21) ? CW : 21) + 1;

    localparam logic [CW-1:0] LAST_CNT = CW'(PERIOD - 1);
    localparam logic [19:0]   MAX_P    = 20'(MAX_POS);
    localparam logic [19:0]   STEP_P   = 20'(STEP);
    localparam logic [19:0]   INIT_P   = 20'(INIT_POS);
    localparam logic [7:0]    SETTLE_N = 8'(SETTLE_FRAMES);
    localparam logic [PW-1:0] BASE_P   = PW'(BASE_WIDTH);

    typedef enum logic [1:0] {
        ST_SLEW,
        ST_SETTLE,
        ST_DONE
    } state_t;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [19:0]   pos_q, pos_d;
    logic [7:0]    settle_q, settle_d;
    state_t        state_q, state_d;
    logic          pwm_q, pwm_d;
    logic          flag_q, flag_d;

    logic          boundary;
    logic [19:0]   tgt;
    logic [19:0]   pos_step;
    logic [7:0]    settle_inc;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q    <= '0;
            pos_q    <= INIT_P;
            settle_q <= '0;
            state_q  <= ST_SETTLE;
            pwm_q    <= 1'b0;
            flag_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            pos_q    <= pos_d;
            settle_q <= settle_d;
            state_q  <= state_d;
            pwm_q    <= pwm_d;
            flag_q   <= flag_d;
        end
    end

    always_comb begin
        boundary   = (cnt_q == LAST_CNT);
        tgt        = (DESIRED > MAX_P) ? MAX_P : DESIRED;
        settle_inc = settle_q + 8'd1;

        // Differences are taken only in the direction of travel, so neither step can wrap.
        if (pos_q < tgt) begin
            pos_step = ((tgt - pos_q) > STEP_P) ? (pos_q + STEP_P) : tgt;
        end else if (pos_q > tgt) begin
            pos_step = ((pos_q - tgt) > STEP_P) ? (pos_q - STEP_P) : tgt;
        end else begin
            pos_step = pos_q;
        end
    end

    always_comb begin
        cnt_d    = boundary ? '0 : cnt_q + 1'b1;
        pos_d    = pos_q;
        settle_d = settle_q;
        state_d  = state_q;
        pwm_d    = (PW'(cnt_q) < (PW'(pos_q) + BASE_P));

        if (boundary) begin
            pos_d = pos_step;
            // A fresh target that differs from POS always wins over settle completion.
            if (pos_q != tgt) begin
                settle_d = '0;
                state_d  = (pos_step == tgt) ? ST_SETTLE : ST_SLEW;
            end else begin
                case (state_q)
                    ST_SLEW: begin
                        settle_d = '0;
                        state_d  = ST_SETTLE;
                    end
                    ST_SETTLE: begin
                        settle_d = settle_inc;
                        if (settle_inc >= SETTLE_N) begin
                            state_d = ST_DONE;
                        end
                    end
                    ST_DONE: begin
                        state_d = ST_DONE;
                    end
                    default: begin
                        settle_d = '0;
                        state_d  = ST_SLEW;
                    end
                endcase
            end
        end

        flag_d = (state_d == ST_DONE);
    end

    assign PWM  = pwm_q;
    assign FLAG = flag_q;
    assign POS  = pos_q;

endmodule

// File: tb/tb_servo_slew_pwm.sv
// Directed bench for servo_slew_pwm with a 100-cycle frame; expectations are hand-derived per frame.
module tb_servo_slew_pwm;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [19:0] DESIRED = 20'd20;
    logic        PWM;
    logic        FLAG;
    logic [19:0] POS;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    servo_slew_pwm #(
        .PERIOD       (100),
        .BASE_WIDTH   (10),
        .MAX_POS      (80),
        .STEP         (5),
        .INIT_POS     (20),
        .SETTLE_FRAMES(2)
    ) dut (
        .CLK    (CLK),
        .RST    (RST),
        .DESIRED(DESIRED),
        .PWM    (PWM),
        .FLAG   (FLAG),
        .POS    (POS)
    );

    // Runs exactly one frame starting right after a boundary; the last edge is the next boundary.
    task automatic run_frame(output int width);
        width = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge CLK);
            #1;
            if (PWM === 1'b1) width++;
        end
    endtask

    task automatic test_reset();
        int w;
        RST = 1'b1;
        DESIRED = 20'd20;
        repeat (3) @(posedge CLK);
        #1;
        total++; if (PWM !== 1'b0) begin bad++; $display("FAIL reset_pwm: got %b want 0", PWM); end
        total++; if (FLAG !== 1'b0) begin bad++; $display("FAIL reset_flag: got %b want 0", FLAG); end
        total++; if (POS !== 20'd20) begin bad++; $display("FAIL reset_pos: got %0d want 20", POS); end
        @(negedge CLK);
        RST = 1'b0;
        run_frame(w);
        total++; if (w != 30) begin bad++; $display("FAIL reset_f1_width: got %0d want 30", w); end
        total++; if (FLAG !== 1'b0) begin bad++; $display("FAIL reset_f1_flag: got %b want 0", FLAG); end
        total++; if (POS !== 20'd20) begin bad++; $display("FAIL reset_f1_pos: got %0d want 20", POS); end
        run_frame(w);
        total++; if (w != 30) begin bad++; $display("FAIL reset_f2_width: got %0d want 30", w); end
        total++; if (FLAG !== 1'b1) begin bad++; $display("FAIL reset_f2_flag: got %b want 1", FLAG); end
    endtask

    task automatic test_slew_up();
        int w;
        int exp_pos [5] = '{25, 30, 33, 33, 33};
        int exp_w   [5] = '{30, 35, 40, 43, 43};
        logic exp_flag [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        DESIRED = 20'd33;
        for (int f = 0; f < 5; f++) begin
            run_frame(w);
            total++; if (POS !== 20'(exp_pos[f])) begin bad++; $display("FAIL slew_pos[%0d]: got %0d want %0d", f, POS, exp_pos[f]); end
            total++; if (FLAG !== exp_flag[f]) begin bad++; $display("FAIL slew_flag[%0d]: got %b want %b", f, FLAG, exp_flag[f]); end
            total++; if (w != exp_w[f]) begin bad++; $display("FAIL slew_width[%0d]: got %0d want %0d", f, w, exp_w[f]); end
        end
    endtask

    task automatic test_clamp();
        int w;
        int prev;
        int expp;
        DESIRED = 20'd200;
        prev = 33;
        for (int n = 1; n <= 10; n++) begin
            run_frame(w);
            expp = (33 + 5 * n > 80) ? 80 : 33 + 5 * n;
            total++; if (POS !== 20'(expp)) begin bad++; $display("FAIL clamp_pos[%0d]: got %0d want %0d", n, POS, expp); end
            total++; if (w != 10 + prev) begin bad++; $display("FAIL clamp_width[%0d]: got %0d want %0d", n, w, 10 + prev); end
            total++; if (FLAG !== 1'b0) begin bad++; $display("FAIL clamp_flag[%0d]: got %b want 0", n, FLAG); end
            prev = expp;
        end
        run_frame(w);
        total++; if (w != 90) begin bad++; $display("FAIL clamp_final_width: got %0d want 90", w); end
        total++; if (FLAG !== 1'b0) begin bad++; $display("FAIL clamp_settle1_flag: got %b want 0", FLAG); end
        run_frame(w);
        total++; if (FLAG !== 1'b1) begin bad++; $display("FAIL clamp_settle2_flag: got %b want 1", FLAG); end
        total++; if (POS !== 20'd80) begin bad++; $display("FAIL clamp_hold_pos: got %0d want 80", POS); end
    endtask

    task automatic test_glitch();
        int w = 0;
        int flag_low = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge CLK);
            #1;
            if (PWM === 1'b1) w++;
            if (FLAG !== 1'b1) flag_low++;
            if (i == 30) DESIRED = 20'd40;
            if (i == 60) DESIRED = 20'd200;
        end
        total++; if (flag_low != 0) begin bad++; $display("FAIL glitch_flag_low_cycles: got %0d want 0", flag_low); end
        total++; if (w != 90) begin bad++; $display("FAIL glitch_width: got %0d want 90", w); end
        total++; if (POS !== 20'd80) begin bad++; $display("FAIL glitch_pos: got %0d want 80", POS); end
        total++; if (FLAG !== 1'b1) begin bad++; $display("FAIL glitch_flag: got %b want 1", FLAG); end
    endtask

    task automatic test_mid_reset();
        int w;
        DESIRED = 20'd40;
        for (int n = 1; n <= 7; n++) begin
            run_frame(w);
            total++; if (POS !== 20'(80 - 5 * n)) begin bad++; $display("FAIL down_pos[%0d]: got %0d want %0d", n, POS, 80 - 5 * n); end
        end
        repeat (20) @(posedge CLK);
        #3;
        total++; if (PWM !== 1'b1) begin bad++; $display("FAIL midreset_pre_pwm: got %b want 1", PWM); end
        RST = 1'b1;
        #1;
        total++; if (PWM !== 1'b0) begin bad++; $display("FAIL midreset_pwm: got %b want 0", PWM); end
        total++; if (POS !== 20'd20) begin bad++; $display("FAIL midreset_pos: got %0d want 20", POS); end
        total++; if (FLAG !== 1'b0) begin bad++; $display("FAIL midreset_flag: got %b want 0", FLAG); end
        DESIRED = 20'd25;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        w = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge CLK);
            #1;
            if (PWM === 1'b1) w++;
            if (i == 98) begin
                total++; if (POS !== 20'd20) begin bad++; $display("FAIL midreset_early_pos: got %0d want 20", POS); end
            end
        end
        total++; if (w != 30) begin bad++; $display("FAIL midreset_width: got %0d want 30", w); end
        total++; if (POS !== 20'd25) begin bad++; $display("FAIL midreset_boundary_pos: got %0d want 25", POS); end
        total++; if (FLAG !== 1'b0) begin bad++; $display("FAIL midreset_after_flag: got %b want 0", FLAG); end
    endtask

    task automatic test_floor();
        int w;
        DESIRED = 20'd3;
        for (int n = 1; n <= 5; n++) begin
            run_frame(w);
            total++; if (POS !== 20'((25 - 5 * n < 3) ? 3 : 25 - 5 * n)) begin
                bad++; $display("FAIL floor_pos[%0d]: got %0d want %0d", n, POS, (25 - 5 * n < 3) ? 3 : 25 - 5 * n);
            end
        end
        DESIRED = 20'd0;
        run_frame(w);
        total++; if (w != 13) begin bad++; $display("FAIL floor_width3: got %0d want 13", w); end
        total++; if (POS !== 20'd0) begin bad++; $display("FAIL floor_pos0: got %0d want 0", POS); end
        run_frame(w);
        total++; if (w != 10) begin bad++; $display("FAIL floor_width0: got %0d want 10", w); end
        total++; if (FLAG !== 1'b0) begin bad++; $display("FAIL floor_flag: got %b want 0", FLAG); end
    endtask

    task automatic test_back_to_back();
        int w;
        // Retarget on the boundary that would have completed settling.
        DESIRED = 20'd4;
        run_frame(w);
        total++; if (POS !== 20'd4) begin bad++; $display("FAIL simul_pos: got %0d want 4", POS); end
        total++; if (FLAG !== 1'b0) begin bad++; $display("FAIL simul_flag: got %b want 0", FLAG); end
        run_frame(w);
        total++; if (FLAG !== 1'b0) begin bad++; $display("FAIL simul_flag2: got %b want 0", FLAG); end
        total++; if (w != 14) begin bad++; $display("FAIL simul_width: got %0d want 14", w); end
        run_frame(w);
        total++; if (FLAG !== 1'b1) begin bad++; $display("FAIL simul_flag3: got %b want 1", FLAG); end
        DESIRED = 20'd50;
        run_frame(w);
        total++; if (POS !== 20'd9) begin bad++; $display("FAIL retgt_pos: got %0d want 9", POS); end
        total++; if (FLAG !== 1'b0) begin bad++; $display("FAIL retgt_flag: got %b want 0", FLAG); end
        DESIRED = 20'd9;
        run_frame(w);
        total++; if (POS !== 20'd9) begin bad++; $display("FAIL eqpos_pos: got %0d want 9", POS); end
        total++; if (FLAG !== 1'b0) begin bad++; $display("FAIL eqpos_flag1: got %b want 0", FLAG); end
        run_frame(w);
        total++; if (FLAG !== 1'b0) begin bad++; $display("FAIL eqpos_flag2: got %b want 0", FLAG); end
        run_frame(w);
        total++; if (FLAG !== 1'b1) begin bad++; $display("FAIL eqpos_flag3: got %b want 1", FLAG); end
        total++; if (w != 19) begin bad++; $display("FAIL eqpos_width: got %0d want 19", w); end
    endtask

    initial begin
        test_reset();
        test_slew_up();
        test_clamp();
        test_glitch();
        test_mid_reset();
        test_floor();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
